// File: rtl/eeprom_test_seq_if.sv
// Request/status bundle between the EEPROM test sequencer and its environment.
//   master : the sequencer (drives WR/RD/ADDR and run status, receives START/ACK)
//   slave  : the downstream controller / host side
// The bidirectional DATA bus is a plain inout port of the sequencer, not part of this bundle.
interface eeprom_test_seq_if;
  logic        START;    // begin a test run (sampled only while idle)
  logic        WR;       // write request
  logic        RD;       // read request
  logic [10:0] ADDR;     // byte address
  logic        ACK;      // one-cycle completion pulse from the controller
  logic        BUSY;     // sequencer not idle
  logic        DONE;     // one-cycle end-of-run pulse
  logic        PASS;     // result of the last run
  logic [7:0]  ERR_CNT;  // saturating readback mismatch count
  logic        TIMEOUT;  // last run aborted on a missing ACK

  modport master (
    input  START, ACK,
    output WR, RD, ADDR, BUSY, DONE, PASS, ERR_CNT, TIMEOUT
  );

  modport slave (
    output START, ACK,
    input  WR, RD, ADDR, BUSY, DONE, PASS, ERR_CNT, TIMEOUT
  );
endinterface

// File: rtl/eeprom_test_seq.sv
// EEPROM write/readback test sequencer.
// Writes NBYTES pattern bytes starting at BASE_ADDR (address wraps at 2048), leaving WAIT_CYC idle
// cycles after each write, then reads every byte back and counts mismatches. A request that sees
// no ACK for TO_CYC cycles aborts the run through a one-cycle fault state.
// Ports:
//   CLK    - clock, rising edge
//   RESET  - asynchronous active-low reset
//   ctl    - request/status bundle (master side)
//   DATA   - 8-bit bidirectional data bus, driven only while WR is high
module eeprom_test_seq #(
  parameter int unsigned NBYTES    = 16,
  parameter logic [10:0] BASE_ADDR = 11'h000,
  parameter int unsigned WAIT_CYC  = 10,
  parameter int unsigned TO_CYC    = 4095
) (
  input  logic              CLK,
  input  logic              RESET,
  eeprom_test_seq_if.master ctl,
  inout  wire  [7:0]        DATA
);

  // One counter serves both the post-write gap and the ACK timeout.
  localparam int unsigned CntMax = (TO_CYC > WAIT_CYC) ? TO_CYC : WAIT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] ToLast  = CntW'(TO_CYC - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(WAIT_CYC - 1);
  localparam logic [10:0]     IdxLast = 11'(NBYTES - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrReq  = 3'd1;
  localparam logic [2:0] StWrGap  = 3'd2;
  localparam logic [2:0] StRdReq  = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;
  localparam logic [2:0] StFault  = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [10:0]     idx_q, idx_d;
  logic [10:0]     addr_q, addr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rd_gap_q, rd_gap_d;
  logic [7:0]      err_q, err_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;

  logic [7:0] pattern;
  logic       wr_en;
  logic       rd_en;

  assign pattern = addr_q[7:0] ^ 8'hA5;
  assign wr_en   = (state_q == StWrReq);
  // rd_gap_q marks the single request-free cycle between consecutive reads.
  assign rd_en   = (state_q == StRdReq) && !rd_gap_q;

  assign DATA = wr_en ? pattern : 8'hzz;

  assign ctl.WR      = wr_en;
  assign ctl.RD      = rd_en;
  assign ctl.ADDR    = addr_q;
  assign ctl.BUSY    = (state_q != StIdle);
  assign ctl.DONE    = (state_q == StFinish) || (state_q == StFault);
  assign ctl.PASS    = pass_q;
  assign ctl.ERR_CNT = err_q;
  assign ctl.TIMEOUT = timeout_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_gap_d  = rd_gap_q;
    err_d     = err_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;

    case (state_q)
      StIdle: begin
        if (ctl.START) begin
          err_d     = 8'd0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          idx_d     = 11'd0;
          addr_d    = BASE_ADDR;
          cnt_d     = '0;
          state_d   = StWrReq;
        end
      end

      StWrReq: begin
        // ACK takes priority over an expiring timeout.
        if (ctl.ACK) begin
          cnt_d   = '0;
          state_d = StWrGap;
        end else if (cnt_q == ToLast) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StWrGap: begin
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            idx_d    = 11'd0;
            addr_d   = BASE_ADDR;
            rd_gap_d = 1'b0;
            state_d  = StRdReq;
          end else begin
            idx_d   = idx_q + 11'd1;
            addr_d  = addr_q + 11'd1;
            state_d = StWrReq;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StRdReq: begin
        if (rd_gap_q) begin
          rd_gap_d = 1'b0;
          cnt_d    = '0;
        end else if (ctl.ACK) begin
          if ((DATA != pattern) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
          end
          cnt_d = '0;
          if (idx_q == IdxLast) begin
            // Result must include a mismatch seen on this final read.
            pass_d  = (err_d == 8'd0);
            state_d = StFinish;
          end else begin
            idx_d    = idx_q + 11'd1;
            addr_d   = addr_q + 11'd1;
            rd_gap_d = 1'b1;
          end
        end else if (cnt_q == ToLast) begin
          state_d = StFault;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StFinish: begin
        state_d = StIdle;
      end

      StFault: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Visible during the fault cycle itself.
    if (state_d == StFault) begin
      timeout_d = 1'b1;
      pass_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      idx_q     <= 11'd0;
      addr_q    <= 11'd0;
      cnt_q     <= '0;
      rd_gap_q  <= 1'b0;
      err_q     <= 8'd0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_gap_q  <= rd_gap_d;
      err_q     <= err_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_eeprom_test_seq.sv
// Directed bench for eeprom_test_seq.
// Instance A: NBYTES=4, BASE=0, WAIT_CYC=10, TO_CYC=20 (nominal, stray, corrupt, timeout, reset).
// Instance B: NBYTES=3, BASE=2046 (address wrap).
module tb_eeprom_test_seq;

  logic CLK;
  logic RESET;

  eeprom_test_seq_if if_a ();
  eeprom_test_seq_if if_b ();
  wire [7:0] data_a;
  wire [7:0] data_b;

  eeprom_test_seq #(
    .NBYTES   (4),
    .BASE_ADDR(11'd0),
    .WAIT_CYC (10),
    .TO_CYC   (20)
  ) dut_a (
    .CLK  (CLK),
    .RESET(RESET),
    .ctl  (if_a),
    .DATA (data_a)
  );

  eeprom_test_seq #(
    .NBYTES   (3),
    .BASE_ADDR(11'd2046),
    .WAIT_CYC (10),
    .TO_CYC   (20)
  ) dut_b (
    .CLK  (CLK),
    .RESET(RESET),
    .ctl  (if_b),
    .DATA (data_b)
  );

  // Stimulus / responder state
  logic       start_a, start_b, stray_start_a;
  logic       ack_a, ack_b;
  logic       rsp_oe_a, rsp_oe_b, probe_a;
  logic [7:0] rsp_val_a, rsp_val_b;
  logic       no_ack_a, stray_a;
  int         corrupt_a;
  logic [7:0] mem_a [0:2047];
  logic [7:0] mem_b [0:2047];
  logic [18:0] wlog_a[$], wlog_b[$];
  logic [10:0] rlog_a[$], rlog_b[$];
  int         gaps_a[$];
  int         rcnt_a, since_a, rcnt_b;
  int         both_a, both_b, done_cnt_a;
  bit         seen_a, prev_a;
  int         idle_a;

  int n_tests;
  int n_fail;

  assign if_a.START = start_a | stray_start_a;
  assign if_a.ACK   = ack_a;
  assign if_b.START = start_b;
  assign if_b.ACK   = ack_b;
  // Probe drives 00 so any concurrent DUT drive shows up as a non-zero value.
  assign data_a = (rsp_oe_a || probe_a) ? (rsp_oe_a ? rsp_val_a : 8'h00) : 8'hzz;
  assign data_b = rsp_oe_b ? rsp_val_b : 8'hzz;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder A: ACK on the third cycle of a request, with optional faults.
  initial begin
    ack_a = 0; rsp_oe_a = 0; rsp_val_a = 0; stray_start_a = 0;
    rcnt_a = 0; since_a = -1;
    forever begin
      @(negedge CLK);
      ack_a = 0; rsp_oe_a = 0; stray_start_a = 0;
      if (!RESET) begin
        rcnt_a = 0; since_a = -1;
      end else if (if_a.WR || if_a.RD) begin
        rcnt_a++;
        if (!no_ack_a && rcnt_a == 3) begin
          rcnt_a = 0;
          ack_a  = 1;
          if (if_a.WR) begin
            mem_a[if_a.ADDR] = data_a;
            wlog_a.push_back({if_a.ADDR, data_a});
            since_a = 0;
          end else begin
            rsp_oe_a  = 1;
            rsp_val_a = (int'(if_a.ADDR) == corrupt_a) ? 8'h00 : mem_a[if_a.ADDR];
            rlog_a.push_back(if_a.ADDR);
          end
        end
      end else begin
        rcnt_a = 0;
        if (since_a >= 0) since_a++;
        if (stray_a && since_a == 3) begin
          ack_a = 1; stray_start_a = 1; stray_a = 0;
        end
      end
    end
  end

  // Responder B: plain memory model.
  initial begin
    ack_b = 0; rsp_oe_b = 0; rsp_val_b = 0; rcnt_b = 0;
    forever begin
      @(negedge CLK);
      ack_b = 0; rsp_oe_b = 0;
      if (RESET && (if_b.WR || if_b.RD)) begin
        rcnt_b++;
        if (rcnt_b == 3) begin
          rcnt_b = 0;
          ack_b  = 1;
          if (if_b.WR) begin
            mem_b[if_b.ADDR] = data_b;
            wlog_b.push_back({if_b.ADDR, data_b});
          end else begin
            rsp_oe_b  = 1;
            rsp_val_b = mem_b[if_b.ADDR];
            rlog_b.push_back(if_b.ADDR);
          end
        end
      end else begin
        rcnt_b = 0;
      end
    end
  end

  // Protocol monitor: WR/RD exclusivity, DONE pulses, idle gaps between requests.
  initial begin
    both_a = 0; both_b = 0; done_cnt_a = 0; seen_a = 0; prev_a = 0; idle_a = 0;
    forever begin
      @(negedge CLK);
      if (if_a.WR && if_a.RD) both_a++;
      if (if_b.WR && if_b.RD) both_b++;
      if (if_a.DONE) done_cnt_a++;
      if ((if_a.WR || if_a.RD) && !prev_a && seen_a) gaps_a.push_back(idle_a);
      if (if_a.WR || if_a.RD) begin
        idle_a = 0; seen_a = 1;
      end else begin
        idle_a++;
      end
      prev_a = if_a.WR || if_a.RD;
    end
  end

  task automatic clear_a();
    wlog_a.delete(); rlog_a.delete(); gaps_a.delete();
    seen_a = 0; done_cnt_a = 0;
  endtask

  task automatic start_run_a();
    clear_a();
    @(negedge CLK);
    start_a = 1;
    @(negedge CLK);
    start_a = 0;
  endtask

  task automatic wait_done_a(input string tag);
    for (int i = 0; i < 1000; i++) begin
      if (if_a.DONE) break;
      @(negedge CLK);
    end
    check_eq(tag, if_a.DONE, 1);
  endtask

  task automatic check_z_a(input string tag);
    probe_a = 1;
    #1;
    check_eq(tag, data_a, 8'h00);
    probe_a = 0;
  endtask

  task automatic check_logs_a(input string tag);
    int exp_gaps[7] = '{10, 10, 10, 10, 1, 1, 1};
    check_eq({tag, "_wr_count"}, wlog_a.size(), 4);
    check_eq({tag, "_rd_count"}, rlog_a.size(), 4);
    for (int k = 0; k < 4 && k < wlog_a.size(); k++) begin
      check_eq({tag, "_wr_addr"}, wlog_a[k][18:8], k);
      check_eq({tag, "_wr_data"}, wlog_a[k][7:0], k[7:0] ^ 8'hA5);
    end
    for (int k = 0; k < 4 && k < rlog_a.size(); k++)
      check_eq({tag, "_rd_addr"}, rlog_a[k], k);
    check_eq({tag, "_gap_count"}, gaps_a.size(), 7);
    for (int k = 0; k < 7 && k < gaps_a.size(); k++)
      check_eq({tag, "_gap_len"}, gaps_a[k], exp_gaps[k]);
  endtask

  initial begin
    int wr_cyc;
    logic [10:0] exp_addr_b[3] = '{11'd2046, 11'd2047, 11'd0};
    logic [7:0]  exp_data_b[3] = '{8'h5B, 8'h5A, 8'hA5};
    n_tests = 0; n_fail = 0;
    RESET = 0; start_a = 0; start_b = 0; probe_a = 0;
    no_ack_a = 0; stray_a = 0; corrupt_a = 4096;
    repeat (3) @(negedge CLK);

    // Reset state
    check_eq("rst_busy", if_a.BUSY, 0);
    check_eq("rst_wr", if_a.WR, 0);
    check_eq("rst_rd", if_a.RD, 0);
    check_eq("rst_done", if_a.DONE, 0);
    check_eq("rst_pass", if_a.PASS, 0);
    check_eq("rst_err", if_a.ERR_CNT, 0);
    check_eq("rst_timeout", if_a.TIMEOUT, 0);
    check_eq("rst_addr", if_a.ADDR, 0);
    check_z_a("rst_data_z");

    // Nominal run; START presented together with reset release
    clear_a();
    @(negedge CLK);
    RESET   = 1;
    start_a = 1;
    @(negedge CLK);
    start_a = 0;
    check_eq("first_start_busy", if_a.BUSY, 1);
    check_eq("first_start_wr", if_a.WR, 1);
    check_eq("first_start_data", data_a, 8'hA5);
    wait_done_a("nom_done");
    check_eq("nom_pass", if_a.PASS, 1);
    check_eq("nom_err", if_a.ERR_CNT, 0);
    check_logs_a("nom");
    repeat (3) @(negedge CLK);
    check_eq("nom_done_pulses", done_cnt_a, 1);
    check_eq("nom_idle_busy", if_a.BUSY, 0);

    // START and ACK pulsed during the first write gap
    stray_a = 1;
    start_run_a();
    wait_done_a("stray_done");
    check_eq("stray_pass", if_a.PASS, 1);
    check_logs_a("stray");
    repeat (3) @(negedge CLK);
    check_eq("stray_done_pulses", done_cnt_a, 1);
    check_eq("stray_fired", stray_a, 0);

    // Corrupted read of address 2
    corrupt_a = 2;
    start_run_a();
    wait_done_a("corr_done");
    check_eq("corr_err", if_a.ERR_CNT, 1);
    check_eq("corr_pass", if_a.PASS, 0);
    repeat (5) @(negedge CLK);
    check_eq("corr_err_hold", if_a.ERR_CNT, 1);
    check_eq("corr_pass_hold", if_a.PASS, 0);
    check_eq("corr_done_pulses", done_cnt_a, 1);
    corrupt_a = 4096;

    // Missing ACK on the first write
    no_ack_a = 1;
    start_run_a();
    wr_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (if_a.DONE) break;
      if (if_a.WR) wr_cyc++;
      @(negedge CLK);
    end
    check_eq("to_wr_cycles", wr_cyc, 20);
    check_eq("to_done", if_a.DONE, 1);
    check_eq("to_timeout", if_a.TIMEOUT, 1);
    check_eq("to_pass", if_a.PASS, 0);
    check_eq("to_wr_low", if_a.WR, 0);
    check_eq("to_rd_low", if_a.RD, 0);
    check_z_a("to_data_z");
    no_ack_a = 0;
    @(negedge CLK);
    check_eq("to_idle_busy", if_a.BUSY, 0);
    check_eq("to_timeout_hold", if_a.TIMEOUT, 1);
    start_run_a();
    check_eq("to_cleared_on_start", if_a.TIMEOUT, 0);
    wait_done_a("recover_done");
    check_eq("recover_pass", if_a.PASS, 1);

    // Reset during the write of byte 1
    start_run_a();
    for (int i = 0; i < 200; i++) begin
      if (if_a.WR && if_a.ADDR == 11'd1) break;
      @(negedge CLK);
    end
    check_eq("mid_reached_byte1", if_a.WR && (if_a.ADDR == 11'd1), 1);
    #2;
    RESET = 0;
    #1;
    check_eq("mid_wr", if_a.WR, 0);
    check_eq("mid_busy", if_a.BUSY, 0);
    check_eq("mid_addr", if_a.ADDR, 0);
    check_z_a("mid_data_z");
    repeat (3) @(negedge CLK);
    check_eq("mid_no_done", done_cnt_a, 0);
    RESET = 1;

    // Address wrap on instance B
    @(negedge CLK);
    start_b = 1;
    @(negedge CLK);
    start_b = 0;
    for (int i = 0; i < 1000; i++) begin
      if (if_b.DONE) break;
      @(negedge CLK);
    end
    check_eq("wrap_done", if_b.DONE, 1);
    check_eq("wrap_pass", if_b.PASS, 1);
    check_eq("wrap_wr_count", wlog_b.size(), 3);
    check_eq("wrap_rd_count", rlog_b.size(), 3);
    for (int k = 0; k < 3 && k < wlog_b.size(); k++) begin
      check_eq("wrap_wr_addr", wlog_b[k][18:8], exp_addr_b[k]);
      check_eq("wrap_wr_data", wlog_b[k][7:0], exp_data_b[k]);
    end
    for (int k = 0; k < 3 && k < rlog_b.size(); k++)
      check_eq("wrap_rd_addr", rlog_b[k], exp_addr_b[k]);

    check_eq("wr_rd_exclusive_a", both_a, 0);
    check_eq("wr_rd_exclusive_b", both_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
